// File: rtl/aes_keyexp_gen.sv
// AES key schedule generator: expands a 128/192/256-bit key one word per cycle
// and writes encrypt (and optionally decrypt) round keys to two RAM ports.
`timescale 1ns/1ps

module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] pw;
    logic [7:0] inv;

    // Multiplicative inverse as a^254, then the affine transform.
    always_comb begin
        pw  = data_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pw  = gfMul(pw, pw);
            inv = gfMul(inv, pw);
        end
        data_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module aes_keyexp_gen #(
    parameter int RAM_AW = 4,
    parameter int DEC_EN = 1
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [1:0]        iKeyLength,
    input  logic [255:0]      iKey,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [3:0]        oNr,
    output logic [RAM_AW-1:0] oRAM_Ke_addr,
    output logic              oRAM_Ke_we,
    output logic [127:0]      oRAM_Ke_data,
    output logic [RAM_AW-1:0] oRAM_Kd_addr,
    output logic              oRAM_Kd_we,
    output logic [127:0]      oRAM_Kd_data
);

    typedef enum logic [1:0] {IDLE, EXPAND, FLUSH, ERR} state_t;

    state_t state_q, state_d;

    logic [255:0]      keyShift_q;
    logic [31:0]       hist_q [8];
    logic [95:0]       rkAcc_q;
    logic [5:0]        wIdx_q;
    logic [5:0]        lastIdx_q;
    logic [3:0]        modCnt_q;
    logic [3:0]        nk_q;
    logic [3:0]        nr_q;
    logic [7:0]        rcon_q;
    logic              keWe_q, kdWe_q;
    logic [RAM_AW-1:0] keAddr_q, kdAddr_q;
    logic [127:0]      keData_q, kdData_q;

    logic [3:0]   nkNew, nrNew;
    logic         startLegal, keyPhase, useRcon;
    logic [31:0]  prevWord, oldWord, sbIn, sbOut, temp, wNew;
    logic [127:0] rkFull, kdRound;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulB(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mulD(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mulE(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [7:0] invMixByte(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
        return mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3);
    endfunction

    function automatic logic [31:0] invMixWord(input logic [31:0] w);
        return {invMixByte(w[31:24], w[23:16], w[15:8],  w[7:0]),
                invMixByte(w[23:16], w[15:8],  w[7:0],   w[31:24]),
                invMixByte(w[15:8],  w[7:0],   w[31:24], w[23:16]),
                invMixByte(w[7:0],   w[31:24], w[23:16], w[15:8])};
    endfunction

    always_ff @(posedge iClk) begin
        if (!iRst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iStart) state_d = (iKeyLength == 2'd3) ? ERR : EXPAND;
            EXPAND:  if (wIdx_q == lastIdx_q) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state_q == EXPAND) || (state_q == FLUSH);
        oDone = (state_q == FLUSH);
        oErr  = (state_q == ERR);
    end

    always_comb begin
        case (iKeyLength)
            2'd0:    begin nkNew = 4'd4; nrNew = 4'd10; end
            2'd1:    begin nkNew = 4'd6; nrNew = 4'd12; end
            default: begin nkNew = 4'd8; nrNew = 4'd14; end
        endcase
    end

    assign startLegal = (state_q == IDLE) && iStart && (iKeyLength != 2'd3);
    assign keyPhase   = wIdx_q < {2'b00, nk_q};
    assign useRcon    = (modCnt_q == 4'd0) && !keyPhase;
    assign prevWord   = hist_q[0];
    assign oldWord    = hist_q[3'(nk_q - 4'd1)];
    assign sbIn       = (modCnt_q == 4'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

    aes_sbox uSbox0 (.data_i(sbIn[31:24]), .data_o(sbOut[31:24]));
    aes_sbox uSbox1 (.data_i(sbIn[23:16]), .data_o(sbOut[23:16]));
    aes_sbox uSbox2 (.data_i(sbIn[15:8]),  .data_o(sbOut[15:8]));
    aes_sbox uSbox3 (.data_i(sbIn[7:0]),   .data_o(sbOut[7:0]));

    // Middle decrypt round keys go through InvMixColumns; first and last stay raw.
    always_comb begin
        if (modCnt_q == 4'd0)
            temp = sbOut ^ {rcon_q, 24'h000000};
        else if ((nk_q == 4'd8) && (modCnt_q == 4'd4))
            temp = sbOut;
        else
            temp = prevWord;
        wNew   = keyPhase ? keyShift_q[255:224] : (oldWord ^ temp);
        rkFull = {rkAcc_q, wNew};
        if ((wIdx_q[5:2] == 4'd0) || (wIdx_q[5:2] == nr_q))
            kdRound = rkFull;
        else
            kdRound = {invMixWord(rkFull[127:96]), invMixWord(rkFull[95:64]),
                       invMixWord(rkFull[63:32]),  invMixWord(rkFull[31:0])};
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            keyShift_q <= '0;
            for (int j = 0; j < 8; j++) hist_q[j] <= '0;
            rkAcc_q    <= '0;
            wIdx_q     <= '0;
            lastIdx_q  <= '0;
            modCnt_q   <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            rcon_q     <= '0;
            keWe_q     <= 1'b0;
            kdWe_q     <= 1'b0;
            keAddr_q   <= '0;
            kdAddr_q   <= '0;
            keData_q   <= '0;
            kdData_q   <= '0;
        end else begin
            keWe_q <= 1'b0;
            kdWe_q <= 1'b0;
            if (startLegal) begin
                keyShift_q <= iKey;
                wIdx_q     <= '0;
                modCnt_q   <= '0;
                rcon_q     <= 8'h01;
                nk_q       <= nkNew;
                nr_q       <= nrNew;
                lastIdx_q  <= {nrNew, 2'b11};
            end else if (state_q == EXPAND) begin
                keyShift_q <= {keyShift_q[223:0], 32'h0};
                hist_q[0]  <= wNew;
                for (int j = 1; j < 8; j++) hist_q[j] <= hist_q[j-1];
                rkAcc_q    <= {rkAcc_q[63:0], wNew};
                wIdx_q     <= wIdx_q + 6'd1;
                modCnt_q   <= (modCnt_q == nk_q - 4'd1) ? 4'd0 : modCnt_q + 4'd1;
                if (useRcon) rcon_q <= xtime(rcon_q);
                if (wIdx_q[1:0] == 2'b11) begin
                    keWe_q   <= 1'b1;
                    keAddr_q <= RAM_AW'(wIdx_q[5:2]);
                    keData_q <= rkFull;
                    kdWe_q   <= (DEC_EN != 0);
                    kdAddr_q <= RAM_AW'(nr_q - wIdx_q[5:2]);
                    kdData_q <= kdRound;
                end
            end
        end
    end

    assign oNr          = nr_q;
    assign oRAM_Ke_addr = keAddr_q;
    assign oRAM_Ke_we   = keWe_q;
    assign oRAM_Ke_data = keData_q;
    assign oRAM_Kd_addr = kdAddr_q;
    assign oRAM_Kd_we   = kdWe_q;
    assign oRAM_Kd_data = kdData_q;

endmodule

// File: tb/tb_aes_keyexp_gen.sv
// Scoreboard bench for aes_keyexp_gen: a FIPS-197 style model queues expected
// writes/pulses with their cycle numbers; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_aes_keyexp_gen;

    logic         iClk = 1'b0;
    logic         iRst_n, iStart;
    logic [1:0]   iKeyLength;
    logic [255:0] iKey;

    logic         oBusy, oDone, oErr, oRAM_Ke_we, oRAM_Kd_we;
    logic [3:0]   oNr, oRAM_Ke_addr, oRAM_Kd_addr;
    logic [127:0] oRAM_Ke_data, oRAM_Kd_data;
    logic         oBusy0, oDone0, oErr0, oRAM_Ke_we0, oRAM_Kd_we0;
    logic [3:0]   oNr0, oRAM_Ke_addr0, oRAM_Kd_addr0;
    logic [127:0] oRAM_Ke_data0, oRAM_Kd_data0;

    always #5 iClk = ~iClk;

    aes_keyexp_gen #(.RAM_AW(4), .DEC_EN(1)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iKeyLength(iKeyLength), .iKey(iKey),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oNr(oNr),
        .oRAM_Ke_addr(oRAM_Ke_addr), .oRAM_Ke_we(oRAM_Ke_we), .oRAM_Ke_data(oRAM_Ke_data),
        .oRAM_Kd_addr(oRAM_Kd_addr), .oRAM_Kd_we(oRAM_Kd_we), .oRAM_Kd_data(oRAM_Kd_data));

    aes_keyexp_gen #(.RAM_AW(4), .DEC_EN(0)) dut0 (
        .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iKeyLength(iKeyLength), .iKey(iKey),
        .oBusy(oBusy0), .oDone(oDone0), .oErr(oErr0), .oNr(oNr0),
        .oRAM_Ke_addr(oRAM_Ke_addr0), .oRAM_Ke_we(oRAM_Ke_we0), .oRAM_Ke_data(oRAM_Ke_data0),
        .oRAM_Kd_addr(oRAM_Kd_addr0), .oRAM_Kd_we(oRAM_Kd_we0), .oRAM_Kd_data(oRAM_Kd_data0));

    typedef struct { int cyc; int addr; logic [127:0] data; } WriteExp;
    typedef struct { int cyc; int nr; } EventExp;

    WriteExp keQ[$], kdQ[$], ke0Q[$];
    EventExp doneQ[$], errQ[$];

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    int busyLo = 1;
    int busyHi = 0;
    int modelNr = 0;
    logic [7:0]  sboxTab [256];
    logic [31:0] wRef [60];

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic report(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [7:0] gmulRef(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic buildSbox();
        logic [7:0] inv, s;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmulRef(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sboxTab[b] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWordRef(input logic [31:0] w);
        return {sboxTab[w[31:24]], sboxTab[w[23:16]], sboxTab[w[15:8]], sboxTab[w[7:0]]};
    endfunction

    function automatic logic [31:0] invMixRef(input logic [31:0] w);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] b [4];
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++) a[c] = w[31-8*c -: 8];
        for (int r = 0; r < 4; r++) begin
            b[r] = 8'h00;
            for (int c = 0; c < 4; c++) b[r] ^= gmulRef(coef[(c-r+4)%4], a[c]);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic calcSchedule(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4*nr+4; i++) begin
            if (i < nk) begin
                wRef[i] = key[255-32*i -: 32];
            end else begin
                t = wRef[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int k = 1; k < i/nk; k++) rc = gmulRef(rc, 8'h02);
                    t = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk > 6 && i % nk == 4) begin
                    t = subWordRef(t);
                end
                wRef[i] = wRef[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic waitTo(input int c);
        while (cyc < c) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // Drives one start pulse in the current cycle T and queues everything it must produce.
    task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key, input bit haveKa,
                                 input logic [127:0] kaLast, input logic [127:0] kaKd1,
                                 output int t);
        int nk, nr;
        logic [127:0] raw, inv;
        t = cyc;
        iStart = 1'b1;
        iKeyLength = len;
        iKey = key;
        if (len == 2'd3) begin
            errQ.push_back('{t+1, modelNr});
        end else begin
            nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
            nr = nk + 6;
            calcSchedule(key, nk, nr);
            for (int r = 0; r <= nr; r++) begin
                raw = {wRef[4*r], wRef[4*r+1], wRef[4*r+2], wRef[4*r+3]};
                inv = {invMixRef(raw[127:96]), invMixRef(raw[95:64]),
                       invMixRef(raw[63:32]), invMixRef(raw[31:0])};
                if (haveKa && r == nr) raw = kaLast;
                if (haveKa && r == nr-1 && kaKd1 != 128'h0) inv = kaKd1;
                keQ.push_back('{t+4*r+5, r, raw});
                ke0Q.push_back('{t+4*r+5, r, raw});
                kdQ.push_back('{t+4*r+5, nr-r, (r == 0 || r == nr) ? raw : inv});
            end
            doneQ.push_back('{t+4*nr+5, nr});
            busyLo = t + 1;
            busyHi = t + 4*nr + 5;
            modelNr = nr;
        end
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        iKeyLength = 2'($urandom);
        iKey = rand256();
    endtask

    task automatic runJob(input logic [1:0] len, input logic [255:0] key, input bit haveKa,
                          input logic [127:0] kaLast, input logic [127:0] kaKd1);
        int t;
        applyStimulus(len, key, haveKa, kaLast, kaKd1, t);
        if (len == 2'd3) waitTo(t + 2);
        else             waitTo(t + 4*(len == 2'd0 ? 10 : len == 2'd1 ? 12 : 14) + 6);
    endtask

    task automatic checkOutput();
        report("reset_zero", {oBusy, oDone, oErr, oNr, oRAM_Ke_addr, oRAM_Ke_we, oRAM_Ke_data,
                              oRAM_Kd_addr, oRAM_Kd_we, oRAM_Kd_data} === '0,
               $sformatf("got busy %b done %b err %b nr %0d kewe %b kdwe %b expected all zero",
                         oBusy, oDone, oErr, oNr, oRAM_Ke_we, oRAM_Kd_we));
        report("reset_zero0", {oBusy0, oDone0, oErr0, oNr0, oRAM_Ke_addr0, oRAM_Ke_we0, oRAM_Ke_data0,
                               oRAM_Kd_addr0, oRAM_Kd_we0, oRAM_Kd_data0} === '0,
               $sformatf("got busy %b done %b err %b nr %0d expected all zero",
                         oBusy0, oDone0, oErr0, oNr0));
    endtask

    always @(negedge iClk) begin : monitor
        WriteExp e;
        EventExp d;
        bit expBusy, expDone, expErr, expKe, expKd, expKe0;
        expBusy = (cyc >= busyLo) && (cyc <= busyHi);
        report("busy", oBusy === expBusy && oBusy0 === expBusy,
               $sformatf("got %b/%b expected %b at cycle %0d", oBusy, oBusy0, expBusy, cyc));
        expDone = doneQ.size() > 0 && doneQ[0].cyc == cyc;
        report("done", oDone === expDone && oDone0 === expDone,
               $sformatf("got %b/%b expected %b at cycle %0d", oDone, oDone0, expDone, cyc));
        if (expDone) begin
            d = doneQ.pop_front();
            report("nr", oNr === 4'(d.nr) && oNr0 === 4'(d.nr),
                   $sformatf("got %0d/%0d expected %0d", oNr, oNr0, d.nr));
        end
        expErr = errQ.size() > 0 && errQ[0].cyc == cyc;
        report("err", oErr === expErr && oErr0 === expErr,
               $sformatf("got %b/%b expected %b at cycle %0d", oErr, oErr0, expErr, cyc));
        if (expErr) begin
            d = errQ.pop_front();
            report("err_nr", oNr === 4'(d.nr),
                   $sformatf("got %0d expected %0d", oNr, d.nr));
        end
        expKe = keQ.size() > 0 && keQ[0].cyc == cyc;
        report("ke_we", oRAM_Ke_we === expKe,
               $sformatf("got %b expected %b at cycle %0d", oRAM_Ke_we, expKe, cyc));
        if (expKe) begin
            e = keQ.pop_front();
            report("ke_data", oRAM_Ke_addr === 4'(e.addr) && oRAM_Ke_data === e.data,
                   $sformatf("got addr %0d data %h expected addr %0d data %h",
                             oRAM_Ke_addr, oRAM_Ke_data, e.addr, e.data));
        end
        expKd = kdQ.size() > 0 && kdQ[0].cyc == cyc;
        report("kd_we", oRAM_Kd_we === expKd,
               $sformatf("got %b expected %b at cycle %0d", oRAM_Kd_we, expKd, cyc));
        if (expKd) begin
            e = kdQ.pop_front();
            report("kd_data", oRAM_Kd_addr === 4'(e.addr) && oRAM_Kd_data === e.data,
                   $sformatf("got addr %0d data %h expected addr %0d data %h",
                             oRAM_Kd_addr, oRAM_Kd_data, e.addr, e.data));
        end
        expKe0 = ke0Q.size() > 0 && ke0Q[0].cyc == cyc;
        report("ke0_we", oRAM_Ke_we0 === expKe0,
               $sformatf("got %b expected %b at cycle %0d", oRAM_Ke_we0, expKe0, cyc));
        if (expKe0) begin
            e = ke0Q.pop_front();
            report("ke0_data", oRAM_Ke_addr0 === 4'(e.addr) && oRAM_Ke_data0 === e.data,
                   $sformatf("got addr %0d data %h expected addr %0d data %h",
                             oRAM_Ke_addr0, oRAM_Ke_data0, e.addr, e.data));
        end
        report("kd0_we", oRAM_Kd_we0 === 1'b0,
               $sformatf("got we %b (addr %0d data %h) expected we 0",
                         oRAM_Kd_we0, oRAM_Kd_addr0, oRAM_Kd_data0));
    end

    initial begin
        int t;
        int lim;
        logic [1:0] len;
        iRst_n = 1'b0;
        iStart = 1'b0;
        iKeyLength = 2'd0;
        iKey = '0;
        buildSbox();
        repeat (3) @(posedge iClk);
        #1;
        checkOutput();
        iRst_n = 1'b1;
        waitTo(cyc + 1);

        runJob(2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0);
        runJob(2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b1,
               128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h13aa29be9c8faff6f770f58000f7bf03);
        runJob(2'd1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1'b1,
               128'ha4970a331a78dc09c418c271e3a41d5d, 128'h0);
        runJob(2'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
               128'h24fc79ccbf0979e9371ac23c6d68de36, 128'h0);
        runJob(2'd3, rand256(), 1'b0, 128'h0, 128'h0);

        // A second start mid-job must be ignored.
        applyStimulus(2'd0, rand256(), 1'b0, 128'h0, 128'h0, t);
        waitTo(t + 10);
        iStart = 1'b1;
        iKeyLength = 2'd2;
        iKey = rand256();
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        waitTo(t + 46);

        // Reset during an AES-256 job aborts it.
        applyStimulus(2'd2, rand256(), 1'b0, 128'h0, 128'h0, t);
        waitTo(t + 20);
        iRst_n = 1'b0;
        lim = t + 20;
        busyHi = lim;
        while (keQ.size() > 0 && keQ[$].cyc > lim) void'(keQ.pop_back());
        while (kdQ.size() > 0 && kdQ[$].cyc > lim) void'(kdQ.pop_back());
        while (ke0Q.size() > 0 && ke0Q[$].cyc > lim) void'(ke0Q.pop_back());
        while (doneQ.size() > 0 && doneQ[$].cyc > lim) void'(doneQ.pop_back());
        @(posedge iClk);
        #1;
        checkOutput();
        iRst_n = 1'b1;
        modelNr = 0;
        waitTo(cyc + 1);

        for (int n = 0; n < 14; n++) begin
            len = 2'($urandom_range(0, 3));
            runJob(len, rand256(), 1'b0, 128'h0, 128'h0);
            waitTo(cyc + $urandom_range(0, 2));
        end

        waitTo(cyc + 5);
        report("queues_empty", keQ.size() == 0 && kdQ.size() == 0 && ke0Q.size() == 0 &&
                               doneQ.size() == 0 && errQ.size() == 0,
               $sformatf("got ke %0d kd %0d ke0 %0d done %0d err %0d pending expected 0",
                         keQ.size(), kdQ.size(), ke0Q.size(), doneQ.size(), errQ.size()));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/aes_keyexp_gen.md
AES_KEYEXP_GEN -- requirements
Module: aes_keyexp_gen

Interface
REQ-001 SHALL have parameter RAM_AW, default 4, meaning the key RAM address width (legal values ≥4).
REQ-002 SHALL have parameter DEC_EN, default 1, meaning decrypt key schedule is generated (0: Kd port never writes).
REQ-003 SHALL have port iClk, input, 1 bit, the clock; reset iRst_n, synchronous, active-low.
REQ-004 SHALL have port iRst_n, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port iStart, input, 1 bit, a request to expand the key.
REQ-006 SHALL have port iKeyLength, input, 2 bits: 0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal.
REQ-007 SHALL have port iKey, input, 256 bits; w0=iKey[255:224], w1=iKey[223:192], and so on; the unused LSBs are ignored for Nk<8.
REQ-008 SHALL have port oBusy, output, 1 bit, high while an expansion is in progress.
REQ-009 SHALL have port oDone, output, 1 bit, a 1-cycle pulse when the expansion completes.
REQ-010 SHALL have port oErr, output, 1 bit, a 1-cycle pulse when an illegal key length is requested.
REQ-011 SHALL have port oNr, output, 4 bits, the round count of the last accepted job.
REQ-012 SHALL have ports oRAM_Ke_addr (output, RAM_AW), oRAM_Ke_we (output, 1) and oRAM_Ke_data (output, 128), the encrypt round key write port.
REQ-013 SHALL have ports oRAM_Kd_addr (output, RAM_AW), oRAM_Kd_we (output, 1) and oRAM_Kd_data (output, 128), the decrypt round key write port.

Function
REQ-014 SHALL implement a four-state FSM with states IDLE, EXPAND, FLUSH and ERR.
- IDLE→EXPAND on iStart with a legal length.
- IDLE→ERR on iStart with iKeyLength=3.
- ERR→IDLE unconditionally.
- EXPAND→FLUSH after word index i=4Nr+3.
- FLUSH→IDLE unconditionally.
REQ-015 SHALL latch iKey, Nk and Nr when iStart is accepted, and ignore changes to iKey or iKeyLength during the job.
REQ-016 SHALL ignore iStart while oBusy=1, with no effect on the job in progress.
REQ-017 SHALL produce one schedule word per EXPAND cycle, for i = 0 up to 4Nr+3.
- For i<Nk: w[i] is taken from the latched key.
- For i≥Nk: w[i] = w[i-Nk] XOR temp.
REQ-018 SHALL compute temp as follows:
- i mod Nk = 0: SubWord(RotWord(w[i-1])) XOR {rcon,24'h0}.
- Nk=8 and i mod 8 = 4: SubWord(w[i-1]).
- Otherwise: w[i-1].
REQ-019 SHALL track i mod Nk with a wrap counter (no divider), keep an 8-word history shift register, and use four instances of the team's existing 8-bit aes_sbox.
REQ-020 SHALL start rcon at 8'h01 and update it by GF(2^8) xtime (polynomial 0x11B) after each use, giving 01,02,…,80,1B,36.
REQ-021 SHALL write the encrypt key register-outputted in the cycle after word i=4r+3 is produced.
- oRAM_Ke_we=1 and oRAM_Ke_addr=r.
- oRAM_Ke_data = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in bits [127:96].
REQ-022 SHALL write the decrypt key when DEC_EN=1, in the same cycle as the Ke write for round r.
- oRAM_Kd_we=1 and oRAM_Kd_addr=Nr-r.
- Data is the raw round key for r=0 and r=Nr.
- Data is InvMixColumns applied per word (multipliers 0e,0b,0d,09) for 1≤r≤Nr-1.
REQ-023 SHALL meet this timing for iStart accepted at cycle T:
- Round r is written at T+4r+5.
- oDone pulses at T+4Nr+5, coincident with the last write.
- oBusy=1 from T+1 to T+4Nr+5 inclusive.
- Total latency is 45/53/61 cycles for AES-128/192/256.
REQ-024 SHALL hold the write strobes at 0 in every cycle that REQ-021/022 do not name; data and address are don't-care when the strobe is low.
REQ-025 SHALL keep oNr at its previous value on an illegal request, with no RAM write and oErr=1 for exactly the cycle after iStart.
REQ-026 SHALL accept a new iStart in the cycle after oDone, i.e. back-to-back jobs.

Reset
REQ-027 SHALL, while iRst_n=0 at a clock edge, force the FSM to IDLE and all outputs (oBusy, oDone, oErr, oNr, both addresses, both strobes and both data buses) to 0.
REQ-028 SHALL, on a reset asserted mid-job, abort the job: no further writes and no oDone pulse; RAM contents already written are unspecified.

Verification
REQ-029 SHALL pass this AES-128 case: key 2b7e151628aed2a6abf7158809cf4f3c → Ke[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, oDone at T+45.
REQ-030 SHALL pass this AES-128 case: key 000102…0f → Ke[10]=Kd[0]=13111d7fe3944a17f307a78b4d2b30c5 and Kd[1]=13aa29be9c8faff6f770f58000f7bf03.
REQ-031 SHALL pass these AES-192/256 cases:
- Key 000102…17 → Ke[12]=a4970a331a78dc09c418c271e3a41d5d, oDone at T+53.
- Key 000102…1f → Ke[14]=24fc79ccbf0979e9371ac23c6d68de36, oDone at T+61, oNr=14.
- Each run produces exactly Nr+1 write strobes per port.
REQ-032 SHALL pass this illegal-length case: iKeyLength=3 with iStart → oErr pulse at T+1, no strobes, oBusy stays 0.
REQ-033 SHALL pass this busy/reset case:
- iStart re-asserted during a job is ignored and the results are unchanged.
- iRst_n=0 at T+20 gives all outputs 0 at T+21 and no oDone.
- A fresh start afterwards yields correct keys.
REQ-034 SHALL pass this DEC_EN case: with DEC_EN=0, oRAM_Kd_we stays 0 throughout the REQ-029 run while the Ke results are unchanged.
